// File: rtl/perip_hc_sr04_emu.sv
// HC-SR04 ultrasonic sensor emulator: bus-programmable echo width, trigger validation, status counters.
// Optional echo-width jitter from a 16-bit LFSR when HC_SR04_EMU_JITTER_EN is defined.
module perip_hc_sr04_emu #(
    parameter int CLK_HZ      = 25000000,
    parameter int MIN_TRIG_US = 10,
    parameter int BURST_US    = 200,
    parameter int TIMEOUT_US  = 38000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    input  logic        trigger,
    output logic        echo
);
    localparam int TICKS_PER_US = CLK_HZ / 1000000;

    typedef enum logic [2:0] {ST_IDLE, ST_TRIG, ST_BURST, ST_ECHO, ST_HOLD} state_t;

    state_t      state_r;
    logic        sync1_r, sync2_r, trig_prev_r;
    logic        echo_r;
    logic [15:0] echo_us_r;
    logic        enable_r, no_object_r, trig_err_r;
    logic [15:0] count_r;
    logic [15:0] presc_r;
    logic [16:0] us_cnt_r;
    logic [16:0] width_r;
    logic [15:0] lfsr_val_s;
    logic [16:0] jitter_s, base_s, width_next_s;
    logic        wr_s, clr_err_s, us_tick_s, rise_s, latch_s;
    logic        unused_s;

    assign wr_s      = cs && wr;
    assign clr_err_s = wr_s && (addr == 5'h04) && d_in[2];
    assign us_tick_s = (presc_r == 16'(TICKS_PER_US - 1));
    assign rise_s    = sync2_r && !trig_prev_r;
    assign latch_s   = enable_r && (state_r == ST_TRIG) && !sync2_r && (us_cnt_r >= 17'(MIN_TRIG_US));
    assign echo      = echo_r;
    assign unused_s  = &{1'b0, d_in[31:16]};

`ifdef HC_SR04_EMU_JITTER_EN
    logic [15:0] lfsr_r;

    function automatic logic lfsr_fb(input logic [15:0] v);
        return v[15] ^ v[13] ^ v[12] ^ v[10];
    endfunction

    // LFSR steps once per accepted measurement
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_r <= 16'hACE1;
        end else if (latch_s) begin
            lfsr_r <= {lfsr_r[14:0], lfsr_fb(lfsr_r)};
        end
    end

    assign lfsr_val_s = lfsr_r;
    assign jitter_s   = {14'h0, lfsr_r[2:0]};
`else
    assign lfsr_val_s = 16'h0;
    assign jitter_s   = 17'h0;
`endif

    // Width captured at the end of a valid trigger; a zero setting still yields a 1 us pulse
    always_comb begin
        base_s = 17'd1;
        if (no_object_r) begin
            base_s = 17'(TIMEOUT_US);
        end else if (echo_us_r != 16'h0) begin
            base_s = {1'b0, echo_us_r};
        end else begin
            base_s = 17'd1;
        end
        width_next_s = base_s + jitter_s;
    end

    // Trigger synchronizer and edge-detect history
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_r     <= 1'b0;
            sync2_r     <= 1'b0;
            trig_prev_r <= 1'b0;
        end else begin
            sync1_r     <= trigger;
            sync2_r     <= sync1_r;
            trig_prev_r <= sync2_r;
        end
    end

    // Bus-writable configuration registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            echo_us_r   <= 16'h0B50;
            enable_r    <= 1'b1;
            no_object_r <= 1'b0;
        end else if (wr_s) begin
            case (addr)
                5'h00: echo_us_r <= d_in[15:0];
                5'h04: begin
                    enable_r    <= d_in[0];
                    no_object_r <= d_in[1];
                end
                default: ;
            endcase
        end
    end

    // Measurement FSM; prescaler restarts on every transition so phases are whole microseconds
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            echo_r     <= 1'b0;
            presc_r    <= 16'h0;
            us_cnt_r   <= 17'h0;
            width_r    <= 17'h1;
            count_r    <= 16'h0;
            trig_err_r <= 1'b0;
        end else begin
            if (clr_err_s) begin
                trig_err_r <= 1'b0;
            end
            presc_r <= us_tick_s ? 16'h0 : presc_r + 16'h1;
            if (!enable_r) begin
                state_r  <= ST_IDLE;
                echo_r   <= 1'b0;
                presc_r  <= 16'h0;
                us_cnt_r <= 17'h0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        presc_r  <= 16'h0;
                        us_cnt_r <= 17'h0;
                        if (rise_s) begin
                            state_r <= ST_TRIG;
                        end
                    end
                    ST_TRIG: begin
                        if (!sync2_r) begin
                            presc_r  <= 16'h0;
                            us_cnt_r <= 17'h0;
                            if (latch_s) begin
                                width_r <= width_next_s;
                                count_r <= count_r + 16'h1;
                                state_r <= ST_BURST;
                            end else begin
                                trig_err_r <= 1'b1;
                                state_r    <= ST_IDLE;
                            end
                        end else if (us_tick_s && (us_cnt_r != 17'h1FFFF)) begin
                            us_cnt_r <= us_cnt_r + 17'h1;
                        end
                    end
                    ST_BURST: begin
                        if (us_tick_s) begin
                            if (us_cnt_r == 17'(BURST_US - 1)) begin
                                us_cnt_r <= 17'h0;
                                echo_r   <= 1'b1;
                                state_r  <= ST_ECHO;
                            end else begin
                                us_cnt_r <= us_cnt_r + 17'h1;
                            end
                        end
                    end
                    ST_ECHO: begin
                        if (us_tick_s) begin
                            if (us_cnt_r == width_r - 17'h1) begin
                                us_cnt_r <= 17'h0;
                                echo_r   <= 1'b0;
                                state_r  <= ST_HOLD;
                            end else begin
                                us_cnt_r <= us_cnt_r + 17'h1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        // A trigger still held high must fall before re-arming
                        if (us_cnt_r >= 17'd10) begin
                            if (!sync2_r) begin
                                presc_r  <= 16'h0;
                                us_cnt_r <= 17'h0;
                                state_r  <= ST_IDLE;
                            end
                        end else if (us_tick_s) begin
                            us_cnt_r <= us_cnt_r + 17'h1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        echo_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Combinational read mux
    always_comb begin
        d_out = 32'h0;
        if (cs && rd) begin
            case (addr)
                5'h00:   d_out = {16'h0, echo_us_r};
                5'h04:   d_out = {30'h0, no_object_r, enable_r};
                5'h08:   d_out = {count_r, 14'h0, trig_err_r, (state_r != ST_IDLE)};
                5'h10:   d_out = {16'h0, lfsr_val_s};
                default: d_out = 32'h0;
            endcase
        end else begin
            d_out = 32'h0;
        end
    end
endmodule

// File: tb/tb_perip_hc_sr04_emu.sv
// Scoreboard bench for perip_hc_sr04_emu: stimulus queues expected reads and echo widths,
// a negedge monitor compares them as the DUT presents read data or echo pulses.
module tb_perip_hc_sr04_emu;
    localparam int TPU       = 4;
    localparam int EXP_DELAY = 3 + 200 * TPU;
`ifdef HC_SR04_EMU_JITTER_EN
    localparam int JIT       = 7 * TPU;
    localparam logic [31:0] LFSR_RST = 32'h0000ACE1;
`else
    localparam int JIT       = 0;
    localparam logic [31:0] LFSR_RST = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst, cs, rd, wr, trigger, echo;
    logic [31:0] d_in, d_out;
    logic [4:0]  addr;

    perip_hc_sr04_emu #(
        .CLK_HZ(4000000), .MIN_TRIG_US(10), .BURST_US(200), .TIMEOUT_US(1500)
    ) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .d_out(d_out), .trigger(trigger), .echo(echo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0, n_err = 0;
    logic [31:0] rd_q[$];
    int          wmin_q[$], wmax_q[$];
    int          last_fall = 0, rise_cyc = 0, pulses_done = 0;
    logic        echo_d = 1'b0;

    // Monitor: reads and echo pulses popped from the scoreboard queues
    always @(negedge clk) begin
        logic [31:0] exp_v;
        int wmin, wmax, w;
        if (cs && rd) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected addr=%h got=%h", addr, d_out);
            end else begin
                exp_v = rd_q.pop_front();
                if (d_out !== exp_v) begin
                    n_err++;
                    $display("FAIL rd addr=%h got=%h exp=%h", addr, d_out, exp_v);
                end
            end
        end
        if (echo === 1'b1 && echo_d === 1'b0) begin
            rise_cyc = cyc;
            n_cmp++;
            if (wmin_q.size() == 0) begin
                n_err++;
                $display("FAIL echo_unexpected rise at cycle %0d, none expected", cyc);
            end else if (cyc - last_fall != EXP_DELAY) begin
                n_err++;
                $display("FAIL echo_delay got=%0d exp=%0d", cyc - last_fall, EXP_DELAY);
            end
        end
        if (echo === 1'b0 && echo_d === 1'b1) begin
            n_cmp++;
            w = cyc - rise_cyc;
            pulses_done++;
            if (wmin_q.size() == 0) begin
                n_err++;
                $display("FAIL echo_width_unexpected got=%0d", w);
            end else begin
                wmin = wmin_q.pop_front();
                wmax = wmax_q.pop_front();
                if (w < wmin || w > wmax) begin
                    n_err++;
                    $display("FAIL echo_width got=%0d exp=[%0d,%0d]", w, wmin, wmax);
                end
            end
        end
        echo_d <= echo;
    end

    task automatic bus_write(input logic [4:0] a, input logic [31:0] v);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, input logic [31:0] exp_v);
        rd_q.push_back(exp_v);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic pulse(input int us, input int wmin, input int wmax, input bit valid);
        @(posedge clk); #1 trigger = 1'b1;
        repeat (us * TPU) @(posedge clk);
        #1 trigger = 1'b0;
        last_fall = cyc;
        if (valid) begin
            wmin_q.push_back(wmin);
            wmax_q.push_back(wmax);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int k = 0;
        while (pulses_done < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        n_cmp++;
        if (pulses_done < target) begin
            n_err++;
            $display("FAIL wait_echo_done timeout done=%0d exp=%0d", pulses_done, target);
        end
    endtask

    task automatic wait_echo_high(input int budget);
        int k = 0;
        while (k < budget) begin
            @(posedge clk); #1;
            if (echo === 1'b1) break;
            k++;
        end
        n_cmp++;
        if (echo !== 1'b1) begin
            n_err++;
            $display("FAIL wait_echo_high timeout echo=%b exp=1", echo);
        end
    endtask

    task automatic check_echo(input string name, input logic exp_v);
        n_cmp++;
        if (echo !== exp_v) begin
            n_err++;
            $display("FAIL %s echo=%b exp=%b", name, echo, exp_v);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 5'h0; d_in = 32'h0; trigger = 1'b0;
        repeat (4) @(posedge clk); #1;
        check_echo("reset_echo", 1'b0);
        rst = 1'b1;
        idle(1);
        check_echo("post_reset_echo", 1'b0);
        bus_read(5'h00, 32'h00000B50);
        bus_read(5'h04, 32'h00000001);
        bus_read(5'h08, 32'h00000000);
        bus_read(5'h10, LFSR_RST);
        bus_read(5'h0C, 32'h00000000);

        // nominal 1000 us echo
        bus_write(5'h00, 32'd1000);
        bus_read(5'h00, 32'd1000);
        pulse(12, 1000 * TPU, 1000 * TPU + JIT, 1'b1);
        wait_pulses(1, 6000);
        idle(60);
        bus_read(5'h08, 32'h00010000);

        // short trigger: error, no echo, then clear
        pulse(5, 0, 0, 1'b0);
        idle(20);
        bus_read(5'h08, 32'h00010002);
        bus_write(5'h04, 32'h5);
        bus_read(5'h08, 32'h00010000);
        bus_read(5'h04, 32'h00000001);

        // rewrite width and retrigger during echo
        pulse(12, 1000 * TPU, 1000 * TPU + JIT, 1'b1);
        wait_echo_high(1000);
        bus_write(5'h00, 32'd500);
        pulse(15, 0, 0, 1'b0);
        bus_read(5'h08, 32'h00020001);
        wait_pulses(2, 6000);
        idle(60);
        pulse(12, 500 * TPU, 500 * TPU + JIT, 1'b1);
        wait_pulses(3, 4000);
        idle(60);
        bus_read(5'h08, 32'h00030000);

        // no-object timeout width
        bus_write(5'h04, 32'h3);
        bus_read(5'h04, 32'h00000003);
        pulse(12, 1500 * TPU, 1500 * TPU + JIT, 1'b1);
        wait_pulses(4, 8000);
        idle(60);
        bus_write(5'h04, 32'h1);

        // disable 300 us into echo
        pulse(12, 1202, 1202, 1'b1);
        wait_echo_high(1000);
        repeat (300 * TPU) @(posedge clk);
        #1;
        bus_write(5'h04, 32'h0);
        @(posedge clk); #1;
        check_echo("disable_echo", 1'b0);
        bus_read(5'h08, 32'h00050000);
        wait_pulses(5, 10);
        pulse(12, 0, 0, 1'b0);
        idle(900);
        bus_read(5'h08, 32'h00050000);

        n_cmp++;
        if (wmin_q.size() != 0 || rd_q.size() != 0) begin
            n_err++;
            $display("FAIL queues_drained pending_echo=%0d pending_rd=%0d exp=0", wmin_q.size(), rd_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
